// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: a small byte FIFO feeding a serialiser
// that sends LSB first on a registered, idle-high TX line.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 217,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_wr_valid,
  input  logic [7:0]                    i_wr_data,
  output logic                          o_wr_ready,
  output logic                          o_tx,
  output logic                          o_busy,
  output logic [$clog2(FIFO_DEPTH):0]   o_level
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int LVL_W  = PTR_W + 1;
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [LVL_W-1:0]  LVL_FULL  = LVL_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  // FIFO storage and bookkeeping
  logic [7:0]       r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_level;

  // Serialiser state
  state_t           r_state;
  state_t           w_state_next;
  logic [BAUD_W-1:0] r_baud;
  logic [BAUD_W-1:0] w_baud_next;
  logic [2:0]       r_bit_idx;
  logic [2:0]       w_bit_idx_next;
  logic [7:0]       r_shift;
  logic [7:0]       w_shift_next;
  logic             r_tx;
  logic             w_tx_next;

  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic             w_baud_end;
  logic [7:0]       w_head;

  // Ready depends only on the registered level (and reset), never on wr_valid,
  // so a pop in the same cycle cannot let a full FIFO accept a byte.
  assign w_full     = (r_level == LVL_FULL);
  assign w_empty    = (r_level == '0);
  assign o_wr_ready = ~w_full & ~i_rst;
  assign w_push     = i_wr_valid & o_wr_ready;
  assign w_head     = r_mem[r_rd_ptr];
  assign w_baud_end = (r_baud == BAUD_LAST);

  assign o_tx    = r_tx;
  assign o_level = r_level;
  assign o_busy  = (r_state != S_IDLE) | ~w_empty;

  // Storage write port; contents need no reset since level gates every read
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  // Pointers wrap naturally because the depth is a power of two
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Frame sequencing: next state, next line level, baud/bit counters and pops
  always_comb begin
    w_state_next   = r_state;
    w_baud_next    = r_baud;
    w_bit_idx_next = r_bit_idx;
    w_shift_next   = r_shift;
    w_tx_next      = r_tx;
    w_pop          = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_tx_next = 1'b1;
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_shift_next = w_head;
          w_tx_next    = 1'b0;
          w_baud_next  = '0;
          w_state_next = S_START;
        end
      end
      S_START: begin
        if (w_baud_end) begin
          w_baud_next    = '0;
          w_tx_next      = r_shift[0];
          w_bit_idx_next = '0;
          w_state_next   = S_DATA;
        end else begin
          w_baud_next = r_baud + BAUD_W'(1);
        end
      end
      S_DATA: begin
        if (w_baud_end) begin
          w_baud_next  = '0;
          w_shift_next = {1'b0, r_shift[7:1]};
          if (r_bit_idx == 3'd7) begin
            w_tx_next    = 1'b1;
            w_state_next = S_STOP;
          end else begin
            w_tx_next      = r_shift[1];
            w_bit_idx_next = r_bit_idx + 3'd1;
          end
        end else begin
          w_baud_next = r_baud + BAUD_W'(1);
        end
      end
      S_STOP: begin
        if (w_baud_end) begin
          w_baud_next = '0;
          if (!w_empty) begin
            // Chain straight into the next start bit with no idle gap
            w_pop        = 1'b1;
            w_shift_next = w_head;
            w_tx_next    = 1'b0;
            w_state_next = S_START;
          end else begin
            w_state_next = S_IDLE;
          end
        end else begin
          w_baud_next = r_baud + BAUD_W'(1);
        end
      end
      default: begin
        w_tx_next    = 1'b1;
        w_baud_next  = '0;
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Serialiser registers; reset truncates any frame and parks the line high
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_baud    <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_tx      <= 1'b1;
    end else begin
      r_state   <= w_state_next;
      r_baud    <= w_baud_next;
      r_bit_idx <= w_bit_idx_next;
      r_shift   <= w_shift_next;
      r_tx      <= w_tx_next;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed and randomised checks of uart_tx_fifo with CLKS_PER_BIT=4, FIFO_DEPTH=4.
`timescale 1ns/1ps
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_valid;
  logic [7:0] wr_data;
  logic       wr_ready;
  logic       tx;
  logic       busy;
  logic [2:0] level;

  int errors = 0;
  int checks = 0;

  uart_tx_fifo #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_wr_valid (wr_valid),
    .i_wr_data  (wr_data),
    .o_wr_ready (wr_ready),
    .o_tx       (tx),
    .o_busy     (busy),
    .o_level    (level)
  );

  always #5 clk = ~clk;

  // UART receiver model: first low sample = start cycle 0, bits sampled mid-bit
  logic [7:0] rx_q [$];
  logic [7:0] rx_byte;
  int rx_cnt = 0;
  bit rx_active = 1'b0;
  int rx_ferr = 0;
  int level_over = 0;

  always @(negedge clk) begin
    if (rst) begin
      rx_active <= 1'b0;
      rx_cnt    <= 0;
    end else if (!rx_active) begin
      if (tx === 1'b0) begin
        rx_active <= 1'b1;
        rx_cnt    <= 1;
      end
    end else begin
      rx_cnt <= rx_cnt + 1;
      if (rx_cnt == 2 && tx !== 1'b0) begin
        rx_active <= 1'b0;
        rx_ferr   <= rx_ferr + 1;
      end else if (rx_cnt >= 6 && rx_cnt <= 34 && ((rx_cnt - 6) % 4) == 0) begin
        rx_byte[(rx_cnt - 6) / 4] <= tx;
      end else if (rx_cnt == 38) begin
        rx_active <= 1'b0;
        if (tx === 1'b1) rx_q.push_back(rx_byte);
        else rx_ferr <= rx_ferr + 1;
      end
    end
  end

  // Occupancy must never exceed the FIFO depth
  always @(negedge clk) begin
    if (rst === 1'b0 && level > 3'd4) level_over <= level_over + 1;
  end

  // Expected line level k cycles after the pop edge of a frame carrying b
  function automatic logic exp_tx(input logic [7:0] b, input int k);
    if (k < 1) return 1'b1;
    if (k <= 4) return 1'b0;
    if (k <= 36) return b[(k - 5) / 4];
    return 1'b1;
  endfunction

  task automatic test_reset();
    rst = 1'b1; wr_valid = 1'b0; wr_data = 8'h00;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (wr_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_low: got %b want 0", wr_ready); end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b want 1", tx); end
    #1 rst = 1'b0;
    #1;
    checks++;
    if (wr_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_after: got %b want 1", wr_ready); end
    checks++;
    if (level !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", level); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    @(negedge clk);
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL reset_idle: tx=%b busy=%b want 1 0", tx, busy); end
    $display("test_reset done");
  endtask

  task automatic test_single();
    @(negedge clk);
    #1 rx_q.delete(); wr_valid = 1'b1; wr_data = 8'h55;
    @(negedge clk);
    checks++;
    if (level !== 3'd1 || busy !== 1'b1 || tx !== 1'b1) begin
      errors++; $display("FAIL single_accept: level=%0d busy=%b tx=%b want 1 1 1", level, busy, tx);
    end
    #1 wr_valid = 1'b0;
    for (int k = 1; k <= 41; k++) begin
      @(negedge clk);
      checks++;
      if (tx !== exp_tx(8'h55, k)) begin errors++; $display("FAIL single_tx cycle %0d: got %b want %b", k, tx, exp_tx(8'h55, k)); end
      if (k == 1) begin
        checks++;
        if (level !== 3'd0) begin errors++; $display("FAIL single_pop: level=%0d want 0", level); end
      end
      if (k == 40) begin
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_40: got %b want 1", busy); end
      end
      if (k == 41) begin
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_41: got %b want 0", busy); end
      end
    end
    checks++;
    if (rx_q.size() != 1 || rx_q[0] !== 8'h55) begin
      errors++; $display("FAIL single_rx: got %0d bytes first=%h want 1 byte 55", rx_q.size(), rx_q.size() > 0 ? rx_q[0] : 8'hxx);
    end
    $display("test_single done");
  endtask

  task automatic test_back_to_back();
    int acc_e[6];
    int n = 0;
    int fall_e = -1;
    logic acc;
    int exp_e[6] = '{0, 1, 2, 3, 4, 42};
    @(negedge clk);
    #1 rx_q.delete(); wr_valid = 1'b1; wr_data = 8'h41;
    for (int e = 0; e < 400; e++) begin
      acc = wr_valid & wr_ready;
      @(negedge clk);
      if (acc) begin acc_e[n] = e; n++; end
      if (e == 4) begin
        checks++;
        if (level !== 3'd4 || wr_ready !== 1'b0) begin
          errors++; $display("FAIL b2b_full: level=%0d ready=%b want 4 0", level, wr_ready);
        end
      end
      if (n == 6 && busy === 1'b0) begin fall_e = e; break; end
      #1;
      if (n < 6) wr_data = 8'h41 + 8'(n);
      else wr_valid = 1'b0;
    end
    checks++;
    if (n != 6) begin errors++; $display("FAIL b2b_count: got %0d want 6", n); end
    for (int i = 0; i < 6 && i < n; i++) begin
      checks++;
      if (acc_e[i] != exp_e[i]) begin errors++; $display("FAIL b2b_accept_edge %0d: got %0d want %0d", i, acc_e[i], exp_e[i]); end
    end
    checks++;
    if (fall_e != 241) begin errors++; $display("FAIL b2b_duration: busy fell after edge %0d want 241", fall_e); end
    checks++;
    if (rx_q.size() != 6) begin errors++; $display("FAIL b2b_rx_count: got %0d want 6", rx_q.size()); end
    for (int i = 0; i < 6 && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== 8'h41 + 8'(i)) begin errors++; $display("FAIL b2b_rx_byte %0d: got %h want %h", i, rx_q[i], 8'h41 + 8'(i)); end
    end
    $display("test_back_to_back done");
  endtask

  task automatic test_reset_mid();
    int fall = -1;
    @(negedge clk);
    #1 rx_q.delete(); wr_valid = 1'b1; wr_data = 8'h61;
    @(negedge clk);
    #1 wr_data = 8'h62;
    @(negedge clk);
    #1 wr_data = 8'h63;
    @(negedge clk);
    #1 wr_valid = 1'b0;
    repeat (48) @(negedge clk);
    checks++;
    if (level !== 3'd1 || busy !== 1'b1 || tx !== 1'b1) begin
      errors++; $display("FAIL mid_before: level=%0d busy=%b tx=%b want 1 1 1", level, busy, tx);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (wr_ready !== 1'b0) begin errors++; $display("FAIL mid_ready_in_rst: got %b want 0", wr_ready); end
    @(negedge clk);
    checks++;
    if (tx !== 1'b1 || level !== 3'd0 || busy !== 1'b0) begin
      errors++; $display("FAIL mid_after_rst: tx=%b level=%0d busy=%b want 1 0 0", tx, level, busy);
    end
    #1 rst = 1'b0;
    checks++;
    if (rx_q.size() != 1 || rx_q[0] !== 8'h61) begin
      errors++; $display("FAIL mid_rx_first: got %0d bytes first=%h want 1 byte 61", rx_q.size(), rx_q.size() > 0 ? rx_q[0] : 8'hxx);
    end
    @(negedge clk);
    #1 rx_q.delete(); wr_valid = 1'b1; wr_data = 8'h0A;
    for (int k = 0; k <= 41; k++) begin
      @(negedge clk);
      if (k == 0) #1 wr_valid = 1'b0;
      if (k >= 1) begin
        checks++;
        if (tx !== exp_tx(8'h0A, k)) begin errors++; $display("FAIL mid_new_tx cycle %0d: got %b want %b", k, tx, exp_tx(8'h0A, k)); end
      end
      if (busy === 1'b0 && fall < 0) fall = k;
    end
    checks++;
    if (fall != 41) begin errors++; $display("FAIL mid_new_busy: fell at %0d want 41", fall); end
    checks++;
    if (rx_q.size() != 1 || rx_q[0] !== 8'h0A) begin
      errors++; $display("FAIL mid_new_rx: got %0d bytes first=%h want 1 byte 0a", rx_q.size(), rx_q.size() > 0 ? rx_q[0] : 8'hxx);
    end
    $display("test_reset_mid done");
  endtask

  task automatic test_full_toggle();
    logic [7:0] exp_b[6] = '{8'h80, 8'h81, 8'h82, 8'h83, 8'h84, 8'hAA};
    int fall = -1;
    @(negedge clk);
    #1 rx_q.delete(); wr_valid = 1'b1; wr_data = 8'h80;
    for (int e = 0; e <= 44; e++) begin
      @(negedge clk);
      if (e == 4 || e == 40) begin
        checks++;
        if (level !== 3'd4 || wr_ready !== 1'b0) begin
          errors++; $display("FAIL toggle_full edge %0d: level=%0d ready=%b want 4 0", e, level, wr_ready);
        end
      end
      if (e == 41) begin
        checks++;
        if (level !== 3'd3 || wr_ready !== 1'b1) begin
          errors++; $display("FAIL toggle_pop: level=%0d ready=%b want 3 1", level, wr_ready);
        end
      end
      if (e == 42) begin
        checks++;
        if (level !== 3'd4) begin errors++; $display("FAIL toggle_refill: level=%0d want 4", level); end
      end
      #1 wr_data = 8'h80 + 8'(e + 1);
      if (e == 44) wr_valid = 1'b0;
    end
    for (int k = 45; k < 400; k++) begin
      @(negedge clk);
      if (busy === 1'b0) begin fall = k; break; end
    end
    checks++;
    if (fall != 241) begin errors++; $display("FAIL toggle_drain: busy fell at %0d want 241", fall); end
    checks++;
    if (rx_q.size() != 6) begin errors++; $display("FAIL toggle_rx_count: got %0d want 6", rx_q.size()); end
    for (int i = 0; i < 6 && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== exp_b[i]) begin errors++; $display("FAIL toggle_rx_byte %0d: got %h want %h", i, rx_q[i], exp_b[i]); end
    end
    $display("test_full_toggle done");
  endtask

  task automatic test_random();
    logic [7:0] sb [$];
    int n = 0;
    int cyc = 0;
    int mism = 0;
    bit drained = 1'b0;
    logic acc;
    @(negedge clk);
    #1 rx_q.delete(); wr_valid = 1'b0; wr_data = 8'h00;
    while (n < 1000 && cyc < 60000) begin
      acc = wr_valid & wr_ready;
      @(negedge clk);
      cyc++;
      if (acc) begin sb.push_back(wr_data); n++; end
      #1;
      wr_valid = (n < 1000) && ($urandom_range(0, 3) != 0);
      wr_data  = 8'($urandom);
    end
    wr_valid = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (busy === 1'b0) begin drained = 1'b1; break; end
    end
    checks++;
    if (n != 1000) begin errors++; $display("FAIL rand_pushes: got %0d want 1000", n); end
    checks++;
    if (!drained) begin errors++; $display("FAIL rand_drain: busy still %b want 0", busy); end
    repeat (4) @(negedge clk);
    checks++;
    if (rx_q.size() != sb.size()) begin errors++; $display("FAIL rand_rx_count: got %0d want %0d", rx_q.size(), sb.size()); end
    for (int i = 0; i < sb.size() && i < rx_q.size(); i++) begin
      if (rx_q[i] !== sb[i]) mism++;
    end
    checks++;
    if (mism != 0) begin errors++; $display("FAIL rand_order: %0d byte differences want 0", mism); end
    checks++;
    if (level_over != 0) begin errors++; $display("FAIL rand_level: %0d cycles above 4 want 0", level_over); end
    checks++;
    if (rx_ferr != 0) begin errors++; $display("FAIL rand_framing: %0d framing errors want 0", rx_ferr); end
    $display("test_random done: %0d bytes", n);
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_reset_mid();
    test_full_toggle();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
